wtm_reset_sequencer: RTL and testbench

Multi-channel reset sequencer. It synchronises an asynchronous board reset into the clock domain, then releases NUM_OUT reset outputs in index order, one per STAGE_DELAY_US interval. It also accepts a software reset request that re-runs the whole sequence without a board reset. It sits at the top of the FPGA between the board reset pin and the CPU, bus and peripheral reset domains.

---
 rtl/wtm_reset_pkg.sv | 33 +++
 rtl/wtm_reset_sync.sv | 35 +++
 rtl/wtm_reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_wtm_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wtm_reset_pkg.sv
// Shared types and constant helpers for the reset sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package wtm_reset_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam longint unsigned US_PER_SEC = 64'd1000000;

  // Cycles per release stage; never less than one so the sequence always advances.
  function automatic int unsigned calc_delay_cycles(input longint unsigned us,
                                                    input longint unsigned hz);
    longint unsigned cycles;
    cycles = (us * hz) / US_PER_SEC;
    if (cycles == 64'd0) begin
      cycles = 64'd1;
    end
    return 32'(cycles);
  endfunction

  // One counter serves both the stage delay and the software hold, so size for the larger.
  function automatic int unsigned calc_cnt_width(input int unsigned d,
                                                 input int unsigned hold);
    int unsigned m;
    m = (d > hold) ? d : hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wtm_reset_sync.sv
// Reset synchroniser: async assert, release after STAGES clock edges.
// Latency: sync_n rises on the STAGES-th rising edge after rst_n deasserts.
// Backpressure: none.
module wtm_reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  output logic sync_n
);

  if (STAGES < 2) begin : g_bad_stages
    $error("wtm_reset_sync: STAGES must be at least 2 (got %0d)", STAGES);
  end

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift a constant one into the chain; the top bit is the released reset.
  always_comb begin
    chain_d = (chain_q << 1) | STAGES'(1);
  end

  // Chain clears immediately on rst_n so a glitch always restarts the full release.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_n = chain_q[STAGES-1];

endmodule

// File: rtl/wtm_reset_sequencer.sv
// Sequenced reset release: sync board reset, then release NUM_OUT resets one per stage delay.
// Latency: bit k releases SYNC_STAGES + (k+1)*D edges after rst_n deasserts; sw request clears next edge.
// Backpressure: none; sw_rst_req is ignored until the synchronised reset has released.
module wtm_reset_sequencer
  import wtm_reset_pkg::*;
#(
  parameter int unsigned NUM_OUT        = 3,
  parameter int unsigned CLOCK_FREQ_HZ  = 10000000,
  parameter int unsigned STAGE_DELAY_US = 1250,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SW_HOLD_CYCLES = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready,
  output logic               busy
);

  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("wtm_reset_sequencer: NUM_OUT must be 1..8 (got %0d)", NUM_OUT);
  end
  if (SW_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("wtm_reset_sequencer: SW_HOLD_CYCLES must be at least 1");
  end

  localparam int unsigned D  = calc_delay_cycles(64'(STAGE_DELAY_US), 64'(CLOCK_FREQ_HZ));
  localparam int unsigned CW = calc_cnt_width(D, SW_HOLD_CYCLES);
  localparam int unsigned SW = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] D_LAST     = CW'(D - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(SW_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_OUT - 1);

  logic sync_n;

  wtm_reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .rst_n  (rst_n),
    .sync_n (sync_n)
  );

  seq_state_e         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [SW-1:0]      stage_q,   stage_d;
  logic               sw_mode_q, sw_mode_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;
  logic               seq_step;

  // Next-state and registered-output logic for HOLD -> SEQ -> RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    sw_mode_d = sw_mode_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    seq_step  = 1'b0;

    if (sw_rst_req && sync_n) begin
      // Software request wins in every state and (re)starts the hold count.
      state_d   = HOLD;
      sw_mode_d = 1'b1;
      cnt_d     = '0;
      stage_d   = '0;
      rst_out_d = '0;
      ready_d   = 1'b0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (sw_mode_q) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = SEQ;
              cnt_d   = '0;
              stage_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (sync_n) begin
            // The edge that first sees sync_n high is also the first delay cycle,
            // which puts bit k on edge SYNC_STAGES + (k+1)*D.
            seq_step = 1'b1;
          end
        end
        SEQ:     seq_step = 1'b1;
        RUN:     state_d  = RUN;
        default: state_d  = HOLD;
      endcase

      if (seq_step) begin
        if (cnt_q == D_LAST) begin
          for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (stage_q == SW'(i)) begin
              rst_out_d[i] = 1'b1;
            end
          end
          cnt_d   = '0;
          stage_d = stage_q + SW'(1);
          if (stage_q == STAGE_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = SEQ;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = SEQ;
        end
      end
    end
  end

  // State and output registers; rst_n forces every output asserted immediately.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      sw_mode_q <= 1'b0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      sw_mode_q <= sw_mode_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_out_n = rst_out_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wtm_reset_sequencer.sv
// Bench for wtm_reset_sequencer: two instances (D=20/3 outputs, and D=1/1 output/3 sync stages).
// Stimulus pushes expected output changes with their edge numbers; a monitor pops on every change.
module tb_wtm_reset_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a_n, rst_b_n, sw_a, sw_b;
  logic [2:0] a_rst;
  logic       a_rdy, a_bsy;
  logic [0:0] b_rst;
  logic       b_rdy, b_bsy;
  logic [7:0] obs_w;
  bit         stim_done = 1'b0;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  wtm_reset_sequencer #(
    .NUM_OUT(3), .CLOCK_FREQ_HZ(10000000), .STAGE_DELAY_US(2),
    .SYNC_STAGES(2), .SW_HOLD_CYCLES(16)
  ) dut_a (
    .clock(clock), .rst_n(rst_a_n), .sw_rst_req(sw_a),
    .rst_out_n(a_rst), .ready(a_rdy), .busy(a_bsy)
  );

  wtm_reset_sequencer #(
    .NUM_OUT(1), .CLOCK_FREQ_HZ(10000000), .STAGE_DELAY_US(0),
    .SYNC_STAGES(3), .SW_HOLD_CYCLES(16)
  ) dut_b (
    .clock(clock), .rst_n(rst_b_n), .sw_rst_req(sw_b),
    .rst_out_n(b_rst), .ready(b_rdy), .busy(b_bsy)
  );

  assign obs_w = {a_rst, a_rdy, a_bsy, b_rst, b_rdy, b_bsy};

  typedef struct {
    int         c;   // expected edge count at observation, -1 = any
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [4:0] A_RESET = 5'b000_0_1;
  localparam logic [4:0] A_1     = 5'b001_0_1;
  localparam logic [4:0] A_2     = 5'b011_0_1;
  localparam logic [4:0] A_RUN   = 5'b111_1_0;
  localparam logic [2:0] B_RESET = 3'b0_0_1;
  localparam logic [2:0] B_RUN   = 3'b1_1_0;

  logic [4:0] cur_a;
  logic [2:0] cur_b;

  task automatic push_a(input int c, input logic [4:0] v);
    cur_a = v;
    exp_q.push_back('{c: c, v: {cur_a, cur_b}});
  endtask

  task automatic push_b(input int c, input logic [2:0] v);
    cur_b = v;
    exp_q.push_back('{c: c, v: {cur_a, cur_b}});
  endtask

  // Move to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Move to 1 ns after rising edge n.
  task automatic to_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
  endtask

  // Monitor: every output change is compared against the head of the queue.
  initial begin : monitor
    exp_t       e;
    logic [7:0] obs;
    bit         first;
    first = 1'b1;
    forever begin
      if (first) begin
        first = 1'b0;
        #3;
      end else begin
        @(obs_w or stim_done);
        if (!stim_done) #1;
      end
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL leftover_expect: %0d expected changes never seen, next v=%b at edge %0d",
                   exp_q.size(), exp_q[0].v, exp_q[0].c);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      obs = obs_w;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change: got %b at edge %0d, none expected", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.v || (e.c >= 0 && e.c != cyc)) begin
          failures++;
          $display("FAIL output_change: got %b at edge %0d, expected %b at edge %0d",
                   obs, cyc, e.v, e.c);
        end
      end
    end
  end

  initial begin : stim
    int base;
    int s;
    int t;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    sw_a    = 1'b0;
    sw_b    = 1'b0;
    cur_a   = A_RESET;
    cur_b   = B_RESET;
    push_a(-1, A_RESET);           // reset state of both instances
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) tick();

    // Power-on release: bits on edges 22, 42, 62; ready/busy flip on 62.
    tick();
    rst_a_n = 1'b1;
    base = cyc;
    push_a(base + 22, A_1);
    push_a(base + 42, A_2);
    push_a(base + 62, A_RUN);
    drain(100);

    // Software request in RUN: clear next edge, 16-cycle hold, then 20 per stage.
    tick();
    sw_a = 1'b1;
    s = cyc + 1;
    push_a(s, A_RESET);
    push_a(s + 36, A_1);
    push_a(s + 56, A_2);
    push_a(s + 76, A_RUN);
    tick();
    sw_a = 1'b0;
    drain(120);

    // Request at stage 1, then a second request 10 cycles into the hold.
    tick();
    sw_a = 1'b1;
    s = cyc + 1;
    push_a(s, A_RESET);
    push_a(s + 36, A_1);
    tick();
    sw_a = 1'b0;
    t = s + 40;
    push_a(t, A_RESET);
    to_edge(t - 1);
    #1;
    sw_a = 1'b1;
    @(posedge clock);
    #2;
    sw_a = 1'b0;
    push_a(t + 46, A_1);
    push_a(t + 66, A_2);
    push_a(t + 86, A_RUN);
    to_edge(t + 9);
    #1;
    sw_a = 1'b1;
    @(posedge clock);
    #2;
    sw_a = 1'b0;
    drain(150);

    // Board reset from RUN, then a 3 ns glitch at edge 30 of the next release.
    tick();
    push_a(cyc, A_RESET);
    rst_a_n = 1'b0;
    repeat (3) tick();
    rst_a_n = 1'b1;
    base = cyc;
    push_a(base + 22, A_1);
    to_edge(base + 30);
    push_a(base + 30, A_RESET);
    #2;
    rst_a_n = 1'b0;
    #3;
    rst_a_n = 1'b1;
    base = base + 30;
    push_a(base + 22, A_1);
    push_a(base + 42, A_2);
    push_a(base + 62, A_RUN);
    drain(120);

    // Single output, D clamped to 1, 3 sync stages; sw request on edge 1 must be ignored.
    tick();
    rst_b_n = 1'b1;
    sw_b    = 1'b1;
    base = cyc;
    push_b(base + 4, B_RUN);
    tick();
    sw_b = 1'b0;
    drain(20);

    // Software request with D=1: release one edge after the 16-cycle hold.
    tick();
    sw_b = 1'b1;
    s = cyc + 1;
    push_b(s, B_RESET);
    push_b(s + 17, B_RUN);
    tick();
    sw_b = 1'b0;
    drain(40);

    repeat (3) tick();
    stim_done = 1'b1;
  end

endmodule
